// File: rtl/piso_bit_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_bit_feeder                                                          |
// | Serializes valid/ready words onto the 1101 detector's serial input.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module piso_bit_feeder #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             last
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_hbuf, w_hbuf_nxt;
    logic             r_hfull, w_hfull_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_data, w_data_nxt;
    logic             r_dv, w_dv_nxt;
    logic             r_last, w_last_nxt;
    logic             w_accept;
    logic             w_word_done;
    logic             w_load;

    // The bit to emit is always at the "head" end of the word; advancing
    // shifts the next bit into that position.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign in_ready    = !r_hfull && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_word_done = (r_state == ST_SHIFT) && (r_cnt == C_WIDTH);
    // Loading on the final bit of the previous word keeps streams gap-free.
    assign w_load      = r_hfull && ((r_state == ST_IDLE) || w_word_done);

    always_comb begin
        w_state_nxt = r_state;
        w_hbuf_nxt  = r_hbuf;
        w_hfull_nxt = r_hfull;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_dv_nxt    = r_dv;
        w_last_nxt  = r_last;

        if (w_load) begin
            w_state_nxt = ST_SHIFT;
            w_hfull_nxt = 1'b0;
            w_shreg_nxt = advance(r_hbuf);
            w_data_nxt  = head_bit(r_hbuf);
            w_dv_nxt    = 1'b1;
            w_last_nxt  = 1'b0;
            w_cnt_nxt   = C_ONE;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (r_cnt < C_WIDTH) begin
                        w_shreg_nxt = advance(r_shreg);
                        w_data_nxt  = head_bit(r_shreg);
                        w_dv_nxt    = 1'b1;
                        w_cnt_nxt   = r_cnt + C_ONE;
                        w_last_nxt  = ((r_cnt + C_ONE) == C_WIDTH);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_data_nxt  = IDLE_BIT;
                        w_dv_nxt    = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_data_nxt = IDLE_BIT;
                    w_dv_nxt   = 1'b0;
                    w_last_nxt = 1'b0;
                end
            endcase
        end

        // Accept requires an empty buffer, load requires a full one, so the
        // two never collide on the same edge.
        if (w_accept) begin
            w_hbuf_nxt  = in_data;
            w_hfull_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hbuf  <= '0;
            r_hfull <= 1'b0;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_data  <= IDLE_BIT;
            r_dv    <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hbuf  <= w_hbuf_nxt;
            r_hfull <= w_hfull_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_dv    <= w_dv_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign data       = r_data;
    assign data_valid = r_dv;
    assign last       = r_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_bit_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_piso_bit_feeder                                                       |
// | Queue-model bench for MSB-first and LSB-first feeders on shared stimulus.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_piso_bit_feeder;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         rdy_m, d_m, dv_m, l_m;
    logic         rdy_l, d_l, dv_l, l_l;

    piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .data(d_m), .data_valid(dv_m), .last(l_m));

    piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .data(d_l), .data_valid(dv_l), .last(l_l));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a holding slot plus a queue of bits still to appear on
    // the serial line. The head of each queue is what is on `data` right now.
    bit         mq_m[$];
    bit         mq_l[$];
    bit         lq[$];
    bit         m_hfull = 1'b0;
    logic [W-1:0] m_hbuf = '0;
    bit         m_acc = 1'b0;
    bit         acc_now, xfer_now;

    always @(posedge clk) begin
        if (rst) begin
            mq_m.delete(); mq_l.delete(); lq.delete();
            m_hfull = 1'b0;
            m_acc   = 1'b0;
        end else begin
            acc_now = in_valid && !m_hfull;
            if (mq_m.size() > 0) begin
                void'(mq_m.pop_front());
                void'(mq_l.pop_front());
                void'(lq.pop_front());
            end
            xfer_now = m_hfull && (mq_m.size() == 0);
            if (xfer_now) begin
                for (int i = 0; i < W; i++) begin
                    mq_m.push_back(m_hbuf[W-1-i]);
                    mq_l.push_back(m_hbuf[i]);
                    lq.push_back(i == W-1);
                end
                m_hfull = 1'b0;
            end
            if (acc_now) begin
                m_hbuf  = in_data;
                m_hfull = 1'b1;
            end
            m_acc = acc_now;
        end
    end

    // Compare and capture on the falling edge, away from the active edge.
    bit  run_cmp = 1'b0;
    int  cyc = 0;
    int  first_cyc = -1;
    int  last_cyc = -1;
    int  nlast_m = 0;
    int  nlast_l = 0;
    bit  cap_m[$];
    bit  cap_l[$];
    bit  e_d_m, e_d_l, e_dv, e_last;

    always @(negedge clk) begin
        if (run_cmp) begin
            if (mq_m.size() > 0) begin
                e_d_m = mq_m[0]; e_d_l = mq_l[0]; e_dv = 1'b1; e_last = lq[0];
            end else begin
                e_d_m = IDLE; e_d_l = IDLE; e_dv = 1'b0; e_last = 1'b0;
            end
            chk("data_msb",  32'(d_m),   32'(e_d_m));
            chk("valid_msb", 32'(dv_m),  32'(e_dv));
            chk("last_msb",  32'(l_m),   32'(e_last));
            chk("ready_msb", 32'(rdy_m), 32'(!m_hfull && !rst));
            chk("data_lsb",  32'(d_l),   32'(e_d_l));
            chk("valid_lsb", 32'(dv_l),  32'(e_dv));
            chk("last_lsb",  32'(l_l),   32'(e_last));
            chk("ready_lsb", 32'(rdy_l), 32'(!m_hfull && !rst));
        end
        cyc++;
        if (dv_m) begin
            cap_m.push_back(d_m);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (l_m) nlast_m++;
        end
        if (dv_l) begin
            cap_l.push_back(d_l);
            if (l_l) nlast_l++;
        end
    end

    int acc_cnt = 0;
    int hold_cnt = 0;
    always @(posedge clk) begin
        if (in_valid && rdy_m) acc_cnt++;
        if (in_valid && !rdy_m && !rst) hold_cnt++;
    end

    task automatic clear_cap();
        cap_m.delete(); cap_l.delete();
        first_cyc = -1; last_cyc = -1;
        nlast_m = 0; nlast_l = 0;
        acc_cnt = 0; hold_cnt = 0;
    endtask

    function automatic logic [31:0] pack(input bit sel_lsb);
        logic [31:0] v = '0;
        int n = sel_lsb ? cap_l.size() : cap_m.size();
        for (int i = 0; i < n && i < 32; i++)
            v = {v[30:0], (sel_lsb ? cap_l[i] : cap_m[i])};
        return v;
    endfunction

    function automatic int count_1101(input logic [31:0] v, input int n);
        int hits = 0;
        for (int i = n - 1; i >= 3; i--)
            if (v[i -: 4] == 4'b1101) hits++;
        return hits;
    endfunction

    // Drives in_valid/in_data and waits (bounded) until the word is taken.
    task automatic offer(input logic [W-1:0] w);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!m_acc && t < 100);
        chk("accept_timeout", 32'(m_acc), 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while ((mq_m.size() > 0 || m_hfull) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        chk("drain_timeout", 32'(mq_m.size() > 0 || m_hfull), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        @(posedge clk); #1;
        run_cmp = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(rdy_m), 32'd0);
        chk("rst_data",  32'({d_m, dv_m, l_m}), 32'd0);
        rst = 1'b0; #1;
        chk("ready_after_rst", 32'(rdy_m), 32'd1);

        // Single MSB-first word
        clear_cap();
        offer(8'hD0);
        drain();
        chk("single_msb_bits", pack(1'b0), 32'h0000_00D0);
        chk("single_lsb_bits", pack(1'b1), 32'h0000_000B);
        chk("single_last_cnt", 32'(nlast_m), 32'd1);
        chk("single_detect",   32'(count_1101(pack(1'b0), cap_m.size())), 32'd1);

        // Back-to-back words with valid held high
        clear_cap();
        offer(8'hDB);
        offer(8'hB6);
        drain();
        chk("b2b_bits",     pack(1'b0), 32'h0000_DBB6);
        chk("b2b_count",    32'(cap_m.size()), 32'd16);
        chk("b2b_span",     32'(last_cyc - first_cyc), 32'd15);
        chk("b2b_last_cnt", 32'(nlast_m), 32'd2);

        // LSB-first order
        clear_cap();
        offer(8'h0B);
        drain();
        chk("lsb_bits", pack(1'b1), 32'h0000_00D0);

        // Reset during an active word, held two edges
        clear_cap();
        offer(8'h5A);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst2_ready", 32'(rdy_m), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst2_bits_cnt", 32'(cap_m.size()), 32'd2);
        chk("rst2_idle", 32'({d_m, dv_m, l_m}), 32'd0);

        // Reset mid-word with a buffered word, then a fresh word
        clear_cap();
        offer(8'hFF);
        offer(8'hAA);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        offer(8'h0F);
        drain();
        chk("rstmid_count", 32'(cap_m.size()), 32'd11);
        chk("rstmid_bits",  pack(1'b0), 32'h0000_070F);

        // Backpressure: third word waits for the second to be transferred
        clear_cap();
        offer(8'h11);
        offer(8'h22);
        offer(8'h33);
        drain();
        chk("bp_bits",    pack(1'b0), 32'h0011_2233);
        chk("bp_accepts", 32'(acc_cnt), 32'd3);
        chk("bp_holds",   32'(hold_cnt), 32'd8);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                in_valid = 1'b0;
            end
            if (!rst && (!in_valid || m_acc)) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = W'($urandom);
            end
        end
        rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
